// File: rtl/par_fifo_buffer.sv
// par_fifo_buffer: circular multi-word FIFO. Each accepted push writes
// PAR_WRITE words, each accepted pop removes PAR_READ words. DEPTH need not
// be a power of two; every pointer wraps by compare-and-subtract.
// Optional macro PAR_FIFO_ERR_EN adds sticky err_overflow / err_underflow.

// Per-lane address generator: (base + OFFSET) mod DEPTH, valid for
// base < DEPTH and OFFSET <= DEPTH, so one conditional subtract suffices.
module par_fifo_wrap #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int OFFSET     = 0
) (
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] wrapped
);
  localparam logic [ADDR_WIDTH:0] OFF = (ADDR_WIDTH+1)'(OFFSET);
  localparam logic [ADDR_WIDTH:0] DEP = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0] sum;

  // Add offset one bit wider, then fold back into 0..DEPTH-1.
  always_comb begin
    sum = {1'b0, base} + OFF;
    if (sum >= DEP) sum = sum - DEP;
  end

  assign wrapped = sum[ADDR_WIDTH-1:0];
endmodule

module par_fifo_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           push,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] push_data,
  output logic                           push_ready,
  input  logic                           pop,
  output logic [PAR_READ*DATA_WIDTH-1:0] pop_data,
  output logic                           pop_valid,
  output logic [CNT_WIDTH-1:0]           count,
  output logic                           full,
`ifdef PAR_FIFO_ERR_EN
  output logic                           err_overflow,
  output logic                           err_underflow,
`endif
  output logic                           empty
);
  localparam logic [CNT_WIDTH:0] PW_C  = (CNT_WIDTH+1)'(PAR_WRITE);
  localparam logic [CNT_WIDTH:0] PR_C  = (CNT_WIDTH+1)'(PAR_READ);
  localparam logic [CNT_WIDTH:0] DEP_C = (CNT_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt, rd_ptr_nxt;

  // Counter carries one spare bit so flag decodes and arithmetic share width.
  logic [CNT_WIDTH:0]    cnt_q, cnt_nxt;

  logic [PAR_WRITE-1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [PAR_READ-1:0][ADDR_WIDTH-1:0]  rd_addr;

  logic push_acc, pop_acc;

  // Flags decode only the registered count: no same-cycle bypass.
  assign push_ready = (cnt_q + PW_C) <= DEP_C;
  assign pop_valid  = cnt_q >= PR_C;
  assign full       = cnt_q == DEP_C;
  assign empty      = cnt_q == '0;
  assign count      = cnt_q[CNT_WIDTH-1:0];

  assign push_acc = push & push_ready;
  assign pop_acc  = pop & pop_valid;

  // Per-lane write addresses.
  for (genvar k = 0; k < PAR_WRITE; k++) begin : g_wr_lane
    par_fifo_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .OFFSET(k)) u_wrap (
      .base    (wr_ptr),
      .wrapped (wr_addr[k])
    );
  end

  // Per-lane read addresses and combinational read; word 0 is oldest.
  for (genvar i = 0; i < PAR_READ; i++) begin : g_rd_lane
    par_fifo_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .OFFSET(i)) u_wrap (
      .base    (rd_ptr),
      .wrapped (rd_addr[i])
    );
    assign pop_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[i]];
  end

  // Pointer advance for a whole accepted transfer.
  par_fifo_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .OFFSET(PAR_WRITE)) u_wr_adv (
    .base    (wr_ptr),
    .wrapped (wr_ptr_nxt)
  );
  par_fifo_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .OFFSET(PAR_READ)) u_rd_adv (
    .base    (rd_ptr),
    .wrapped (rd_ptr_nxt)
  );

  // Occupancy update; stays within 0..DEPTH because acceptance is gated.
  always_comb begin
    cnt_nxt = cnt_q;
    if (push_acc) cnt_nxt = cnt_nxt + PW_C;
    if (pop_acc)  cnt_nxt = cnt_nxt - PR_C;
  end

  // Pointer/count state: reset beats clear, clear beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr_nxt;
      if (pop_acc)  rd_ptr <= rd_ptr_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Storage write: memory is never reset and untouched by clear.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && push_acc) begin
      for (int k = 0; k < PAR_WRITE; k++)
        mem[wr_addr[k]] <= push_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef PAR_FIFO_ERR_EN
  // Sticky illegal-request flags, cleared by reset or clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push && !push_ready) err_overflow  <= 1'b1;
      if (pop  && !pop_valid)  err_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_par_fifo_buffer.sv
// Directed table-driven bench for par_fifo_buffer
// (DATA_WIDTH=16, DEPTH=6, PAR_WRITE=2, PAR_READ=3).
module tb_par_fifo_buffer;
  logic        clk = 1'b0;
  logic        rst_n, clear, push, pop;
  logic [31:0] push_data;
  logic [47:0] pop_data;
  logic        push_ready, pop_valid, full, empty;
  logic [2:0]  count;
`ifdef PAR_FIFO_ERR_EN
  logic        err_overflow, err_underflow;
`endif

  always #5 clk = ~clk;

  par_fifo_buffer #(.DATA_WIDTH(16), .DEPTH(6), .PAR_WRITE(2), .PAR_READ(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .push       (push),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop        (pop),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .count      (count),
    .full       (full),
`ifdef PAR_FIFO_ERR_EN
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
`endif
    .empty      (empty)
  );

  typedef struct {
    logic        push, pop, clr;
    logic [31:0] din;
    logic [2:0]  cnt;
    logic [3:0]  flg;   // {full, empty, push_ready, pop_valid}
    logic        chk;
    logic [47:0] dout;
    logic        ovf, unf;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic p, input logic q, input logic c, input logic [31:0] d,
                     input logic [2:0] cn, input logic [3:0] f, input logic ck,
                     input logic [47:0] o, input logic ov, input logic un);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.din = d; v.cnt = cn; v.flg = f;
    v.chk = ck; v.dout = o; v.ovf = ov; v.unf = un;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Reset with push held high
    rst_n = 1'b0; clear = 1'b0; push = 1'b1; pop = 1'b0; push_data = 32'h00AA_00BB;
    repeat (2) @(posedge clk);
    #1;
    check("reset count", 64'(count), 64'd0);
    check("reset flags", 64'({full, empty, push_ready, pop_valid}), 64'b0110);
`ifdef PAR_FIFO_ERR_EN
    check("reset err", 64'({err_overflow, err_underflow}), 64'b00);
`endif
    @(negedge clk);
    rst_n = 1'b1; push = 1'b0;

    //   push pop clr din           cnt flg     chk dout                  ovf unf
    add(1, 0, 0, 32'h0002_0001, 2, 4'b0010, 0, 48'h0,                 0, 0);
    add(1, 0, 0, 32'h0004_0003, 4, 4'b0011, 1, 48'h0003_0002_0001,   0, 0);
    add(1, 0, 0, 32'h0006_0005, 6, 4'b1001, 1, 48'h0003_0002_0001,   0, 0);
    add(1, 0, 0, 32'h00FF_00EE, 6, 4'b1001, 1, 48'h0003_0002_0001,   1, 0);
    add(0, 1, 0, 32'h0,         3, 4'b0011, 1, 48'h0006_0005_0004,   1, 0);
    add(0, 1, 0, 32'h0,         0, 4'b0110, 0, 48'h0,                 1, 0);
    add(0, 1, 0, 32'h0,         0, 4'b0110, 0, 48'h0,                 1, 1);
    add(1, 0, 0, 32'h000B_000A, 2, 4'b0010, 0, 48'h0,                 1, 1);
    add(1, 0, 0, 32'h000D_000C, 4, 4'b0011, 1, 48'h000C_000B_000A,   1, 1);
    add(1, 0, 0, 32'h000F_000E, 6, 4'b1001, 1, 48'h000C_000B_000A,   1, 1);
    add(0, 1, 0, 32'h0,         3, 4'b0011, 1, 48'h000F_000E_000D,   1, 1);
    add(0, 1, 0, 32'h0,         0, 4'b0110, 0, 48'h0,                 1, 1);
    add(1, 0, 0, 32'h0012_0011, 2, 4'b0010, 0, 48'h0,                 1, 1);
    add(1, 0, 0, 32'h0014_0013, 4, 4'b0011, 1, 48'h0013_0012_0011,   1, 1);
    add(1, 1, 0, 32'h0016_0015, 3, 4'b0011, 1, 48'h0016_0015_0014,   1, 1);
    add(1, 0, 0, 32'h0018_0017, 5, 4'b0001, 1, 48'h0016_0015_0014,   1, 1);
    add(1, 1, 1, 32'h00EE_00DD, 0, 4'b0110, 0, 48'h0,                 0, 0);
    add(1, 0, 0, 32'h0022_0021, 2, 4'b0010, 0, 48'h0,                 0, 0);
    add(1, 0, 0, 32'h0024_0023, 4, 4'b0011, 1, 48'h0023_0022_0021,   0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      push = tv[i].push; pop = tv[i].pop; clear = tv[i].clr; push_data = tv[i].din;
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", i), 64'(count), 64'(tv[i].cnt));
      check($sformatf("v%0d flags", i), 64'({full, empty, push_ready, pop_valid}), 64'(tv[i].flg));
      if (tv[i].chk)
        check($sformatf("v%0d pop_data", i), 64'(pop_data), 64'(tv[i].dout));
`ifdef PAR_FIFO_ERR_EN
      check($sformatf("v%0d err", i), 64'({err_overflow, err_underflow}), 64'({tv[i].ovf, tv[i].unf}));
`endif
    end

    // Hold inputs idle one cycle: state must not move
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
    check("idle count", 64'(count), 64'd4);
    check("idle pop_data", 64'(pop_data), 64'h0023_0022_0021);

    // Mid-run reset with push and pop both requested
    @(negedge clk);
    rst_n = 1'b0; push = 1'b1; pop = 1'b1; push_data = 32'h0055_0044;
    @(posedge clk);
    #1;
    check("mid reset count", 64'(count), 64'd0);
    check("mid reset flags", 64'({full, empty, push_ready, pop_valid}), 64'b0110);

    // First push after reset lands at address 0
    @(negedge clk);
    rst_n = 1'b1; pop = 1'b0; push = 1'b1; push_data = 32'h0032_0031;
    @(posedge clk);
    @(negedge clk);
    push_data = 32'h0034_0033;
    @(posedge clk);
    #1;
    check("post reset pop_data", 64'(pop_data), 64'h0033_0032_0031);
    @(negedge clk);
    push = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
